chorus_multi: RTL and testbench
===============================

Name: chorus_multi

Overview:
- Multi-voice chorus engine; parametrised successor of the single-voice chorus.
- Per audio sample it reads VOICES modulated-delay taps from smart_ram, then mixes them with the dry input.
- Each voice has its own triangle LFO. Voice phases are spread evenly across the LFO period.
- Sits between the sample scheduler (my_turn/done handshake) and the smart_ram read port (rd/offset/read_finish).

Parameters:
- DATA_W, 16, sample width, signed two's complement.
- ADDR_W, 13, smart_ram offset width.
- VOICES, 2, number of delay taps; legal values 1, 2, 4, 8.
- BASE_DELAY, 512, fixed delay component, in samples.
- LFO_W, 8, LFO counter width; swing is 0..2^LFO_W-1. Constraint: BASE_DELAY + 2^LFO_W - 1 < 2^ADDR_W.
- LFO_DIV, 1, number of completed samples per LFO step; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  block enable; sampled only in IDLE.
- my_turn  in  1  scheduler grant; a sample starts when cs & my_turn in IDLE.
- data_in  in  DATA_W  dry sample; captured at start.
- done  out  1  one-cycle pulse; data_out is valid from this cycle.
- data_out  out  DATA_W  mixed sample; held until the next done.
- sram_rd  out  1  read request to smart_ram.
- sram_offset  out  ADDR_W  delay relative to the smart_ram write head; stable while sram_rd=1.
- sram_data_in  in  DATA_W  read data from smart_ram.
- sram_read_finish  in  1  read complete; sram_data_in is valid in this cycle.

Behaviour:
- Reset (async, any state): state=IDLE, sram_rd=0, sram_offset=0, done=0, data_out=0, accumulator=0, voice index=0, LFO divider=0.
  - LFO reset values: lfo[v] = v*2^LFO_W/VOICES, direction up.
- IDLE:
  - If cs & my_turn: latch data_in to dry, clear accumulator, set v=0, go to READ.
  - Otherwise stay.
- READ:
  - sram_rd=1, sram_offset=BASE_DELAY+lfo[v] (zero-extended).
  - Hold until sram_read_finish=1. On that cycle, add sign-extended sram_data_in to the accumulator.
  - If v==VOICES-1, go to MIX. Otherwise v++ and go to GAP.
- GAP: one cycle, sram_rd=0, then READ. This lets smart_ram see a fresh request.
- MIX: data_out_next = (dry >>> 1) + (acc >>> (1+log2(VOICES))). All shifts are arithmetic, truncating toward −inf.
  - Accumulator width is DATA_W+log2(VOICES). No overflow is possible; the result fits DATA_W.
- DONE: done=1 for exactly one cycle, data_out registered. LFO divider advances, then go to IDLE.
- Back-to-back: if my_turn is still high in IDLE, the next sample starts on the next cycle. There is no re-arm requirement.
- Latency, start cycle (IDLE with grant) to done:
  - Read latency L cycles = cycles with sram_rd high, up to and including the read_finish cycle.
  - Total = 1 + VOICES*L + (VOICES-1) + 2.
- LFO update: divider counts completed samples.
  - When it reaches LFO_DIV-1, it wraps to 0 and every lfo[v] steps ±1.
  - Turnaround: at 2^LFO_W-1 going up, the next value is 2^LFO_W-2 and direction becomes down. At 0 going down, the next value is 1, direction up. No value repeats.
- sram_read_finish outside READ: ignored.
- cs or my_turn dropping mid-sample: current sample completes normally.
- data_in changes after start: no effect until the next start.

Optional Feature:
- Macro CHORUS_MULTI_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit), sampled at start.
  - If bypass=1: IDLE→DONE directly, data_out=data_in, no SRAM reads, LFOs still advance.
  - Latency is 2 cycles.
- Undefined: the bypass port does not exist; every sample performs VOICES reads.

Test Plan:
- Reset: assert rst mid-READ (sram_rd=1) → same cycle sram_rd=0, done=0, data_out=0; next sample reads offsets 512 and 640.
- Basic mix:
  - Setup: defaults, bench SRAM model returns data=offset after L=3, my_turn=1, data_in=4.
  - Sample 1 → reads 512 then 640, data_out=2+(1152>>>2)=290, done at cycle 1+6+1+2=10 after start.
  - Sample 2 → offsets 513/641, data_out=2+(1154>>>2)=290.
- LFO turnaround: run 127 samples → voice1 offset 767 (lfo=255); next sample → 766; voice0 keeps rising (512+128=640 on sample 129).
- Negative mix: VOICES=4, SRAM returns −8 for every read, data_in=−3 → acc=−32, data_out=(−3>>>1)+(−32>>>3)=−2+−4=−6.
- Handshake stress:
  - read_finish pulsed in GAP/IDLE → ignored.
  - my_turn dropped after start → done still pulses once.
  - my_turn held high → consecutive done pulses with exactly one IDLE cycle between them.
- Bypass (macro defined): bypass=1, data_in=0x1234 → done 2 cycles after start, data_out=0x1234, sram_rd never asserted; the LFO has still advanced on the next normal sample.

Source files
------------

// File: rtl/chorus_multi.sv
// chorus_multi: multi-voice chorus engine.
//
// For every audio sample granted by the scheduler, the block reads VOICES
// modulated-delay taps from smart_ram and mixes them with the dry input:
//   data_out = (dry >>> 1) + (sum_of_taps >>> (1 + log2(VOICES)))
// Each voice has its own triangle LFO. Voice phases start evenly spread
// across the LFO period, and every LFO steps once per LFO_DIV completed
// samples.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cs, my_turn       block enable and scheduler grant (sampled in IDLE)
//   data_in           dry sample, captured when a sample starts
//   done              one-cycle pulse; data_out is valid from this cycle
//   data_out          mixed sample, held until the next done
//   sram_rd           read request to smart_ram
//   sram_offset       delay behind the smart_ram write head (stable while sram_rd)
//   sram_data_in      read data from smart_ram
//   sram_read_finish  read complete; sram_data_in valid in this cycle
//   bypass            (only with CHORUS_MULTI_BYPASS_EN) pass data_in straight
//                     through with no SRAM reads; LFOs still advance
//
// Optional feature macro: CHORUS_MULTI_BYPASS_EN.
module chorus_multi #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 13,
  parameter int VOICES     = 2,
  parameter int BASE_DELAY = 512,
  parameter int LFO_W      = 8,
  parameter int LFO_DIV    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              my_turn,
  input  logic [DATA_W-1:0] data_in,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              sram_rd,
  output logic [ADDR_W-1:0] sram_offset,
  input  logic [DATA_W-1:0] sram_data_in,
  input  logic              sram_read_finish
`ifdef CHORUS_MULTI_BYPASS_EN
  ,
  input  logic              bypass
`endif
);

  // state  | meaning
  // IDLE   | waiting for cs & my_turn
  // READ   | sram_rd high for voice vidx until sram_read_finish
  // GAP    | one cycle with sram_rd low between voice reads
  // MIX    | combine dry and accumulated taps into data_out
  // DONE   | done pulse, LFO divider/LFO update

  localparam int VLOG  = $clog2(VOICES);
  localparam int VW    = (VOICES > 1) ? VLOG : 1;
  localparam int ACC_W = DATA_W + VLOG;
  localparam int DIV_W = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;
  localparam logic [LFO_W-1:0] LFO_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_GAP,
    S_MIX,
    S_DONE
  } state_t;

  state_t                   state, state_next;
  logic signed [DATA_W-1:0] dry, dry_next;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic [VW-1:0]            vidx, vidx_next;
  logic                     load_out;
  logic [DATA_W-1:0]        out_value;

  logic [LFO_W-1:0]         lfo [VOICES];
  logic [VOICES-1:0]        lfo_down;
  logic [DIV_W-1:0]         div_cnt;

  // One extra bit of headroom so the sum of the two halves never wraps
  // before truncation back to DATA_W.
  logic signed [ACC_W:0]    dry_ext, acc_ext, mix_sum;

  assign dry_ext = (ACC_W+1)'(dry);
  assign acc_ext = (ACC_W+1)'(acc);
  assign mix_sum = (dry_ext >>> 1) + (acc_ext >>> (1 + VLOG));

  assign sram_offset = sram_rd ? (ADDR_W'(BASE_DELAY) + ADDR_W'(lfo[vidx])) : '0;

  always_comb begin
    state_next = state;
    dry_next   = dry;
    acc_next   = acc;
    vidx_next  = vidx;
    sram_rd    = 1'b0;
    done       = 1'b0;
    load_out   = 1'b0;
    out_value  = data_out;
    case (state)
      S_IDLE: begin
        if (cs && my_turn) begin
          dry_next   = data_in;
          acc_next   = '0;
          vidx_next  = '0;
          state_next = S_READ;
`ifdef CHORUS_MULTI_BYPASS_EN
          if (bypass) begin
            load_out   = 1'b1;
            out_value  = data_in;
            state_next = S_DONE;
          end
`endif
        end
      end
      S_READ: begin
        sram_rd = 1'b1;
        if (sram_read_finish) begin
          acc_next = acc + ACC_W'($signed(sram_data_in));
          if (vidx == VW'(VOICES - 1)) begin
            state_next = S_MIX;
          end else begin
            vidx_next  = vidx + VW'(1);
            state_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        state_next = S_READ;
      end
      S_MIX: begin
        load_out   = 1'b1;
        out_value  = mix_sum[DATA_W-1:0];
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      dry      <= '0;
      acc      <= '0;
      vidx     <= '0;
      data_out <= '0;
    end else begin
      state <= state_next;
      dry   <= dry_next;
      acc   <= acc_next;
      vidx  <= vidx_next;
      if (load_out) begin
        data_out <= out_value;
      end
    end
  end

  // Triangle LFOs: bounce at both ends without repeating the end value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      lfo_down <= '0;
      for (int v = 0; v < VOICES; v++) begin
        lfo[v] <= LFO_W'((v * (1 << LFO_W)) / VOICES);
      end
    end else if (state == S_DONE) begin
      if (div_cnt == DIV_W'(LFO_DIV - 1)) begin
        div_cnt <= '0;
        for (int v = 0; v < VOICES; v++) begin
          if (!lfo_down[v]) begin
            if (lfo[v] == LFO_MAX) begin
              lfo[v]      <= LFO_MAX - LFO_W'(1);
              lfo_down[v] <= 1'b1;
            end else begin
              lfo[v] <= lfo[v] + LFO_W'(1);
            end
          end else begin
            if (lfo[v] == '0) begin
              lfo[v]      <= LFO_W'(1);
              lfo_down[v] <= 1'b0;
            end else begin
              lfo[v] <= lfo[v] - LFO_W'(1);
            end
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_chorus_multi.sv
`timescale 1ns/1ps
module tb_chorus_multi;
  localparam int DW   = 16;
  localparam int AW   = 13;
  localparam int V    = 2;
  localparam int BASE = 512;
  localparam int LW   = 8;
  localparam int DIV  = 1;
  localparam int V4   = 4;
  localparam int DIV4 = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs, my_turn;
  logic [DW-1:0] data_in;
  logic          done;
  logic [DW-1:0] data_out;
  logic          sram_rd;
  logic [AW-1:0] sram_offset;
  logic [DW-1:0] sram_data_in;
  logic          sram_read_finish;

  logic          cs4, my_turn4, done4, rd4, fin4;
  logic [DW-1:0] data_in4, data_out4, d4;
  logic [AW-1:0] off4;

`ifdef CHORUS_MULTI_BYPASS_EN
  logic bypass;
  logic bypass4;
`endif

  always #5 clk = ~clk;

  chorus_multi #(.DATA_W(DW), .ADDR_W(AW), .VOICES(V), .BASE_DELAY(BASE),
                 .LFO_W(LW), .LFO_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .cs(cs), .my_turn(my_turn), .data_in(data_in),
    .done(done), .data_out(data_out), .sram_rd(sram_rd),
    .sram_offset(sram_offset), .sram_data_in(sram_data_in),
    .sram_read_finish(sram_read_finish)
`ifdef CHORUS_MULTI_BYPASS_EN
    , .bypass(bypass)
`endif
  );

  chorus_multi #(.DATA_W(DW), .ADDR_W(AW), .VOICES(V4), .BASE_DELAY(BASE),
                 .LFO_W(LW), .LFO_DIV(DIV4)) dut4 (
    .clk(clk), .rst(rst), .cs(cs4), .my_turn(my_turn4), .data_in(data_in4),
    .done(done4), .data_out(data_out4), .sram_rd(rd4),
    .sram_offset(off4), .sram_data_in(d4),
    .sram_read_finish(fin4)
`ifdef CHORUS_MULTI_BYPASS_EN
    , .bypass(bypass4)
`endif
  );

  int tests = 0;
  int fails = 0;
  int samples;
  int cfg_lat;
  bit cfg_rnd, cfg_spur;
  int off_q[$], dat_q[$], lat_q[$], off4_q[$];
  int rd_cycles;
  int cnt, cur_lat, first_off, cnt4;

  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Triangle wave position p -> LFO value, period 2*(2^LW) - 2.
  function automatic int tri_wave(input int p);
    int m, per, r;
    m   = 1 << LW;
    per = 2 * m - 2;
    r   = p % per;
    return (r < m) ? r : per - r;
  endfunction

  // smart_ram model for the main instance: finish after cur_lat rd cycles.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      sram_read_finish = 1'b0;
      cnt = 0;
    end else begin
      if (sram_read_finish) sram_read_finish = 1'b0;
      if (sram_rd) begin
        if (cnt == 0) begin
          cur_lat   = (cfg_lat != 0) ? cfg_lat : int'($urandom_range(1, 4));
          first_off = int'(sram_offset);
        end else begin
          check("offset_stable", int'(sram_offset), first_off);
        end
        cnt++;
        rd_cycles++;
        if (cnt == cur_lat) begin
          sram_read_finish = 1'b1;
          sram_data_in = cfg_rnd ? DW'($urandom) : DW'(sram_offset);
          off_q.push_back(int'(sram_offset));
          dat_q.push_back(int'($signed(sram_data_in)));
          lat_q.push_back(cur_lat);
          cnt = 0;
        end
      end else begin
        cnt = 0;
        if (cfg_spur && $urandom_range(0, 2) == 0) begin
          sram_read_finish = 1'b1;
          sram_data_in = DW'($urandom);
        end
      end
    end
  end

  // smart_ram model for the 4-voice instance: always -8 after 2 cycles.
  always @(posedge clk) begin
    #2;
    if (fin4) fin4 = 1'b0;
    if (rd4) begin
      cnt4++;
      if (cnt4 == 2) begin
        fin4 = 1'b1;
        d4 = 16'hFFF8;
        off4_q.push_back(int'(off4));
        cnt4 = 0;
      end
    end else begin
      cnt4 = 0;
    end
  end

  // Entered at a negedge with the DUT in IDLE; returns at the negedge of the
  // IDLE cycle following done.
  task automatic run_sample(input logic [DW-1:0] din, input bit drop, input bit keep,
                            input bit byp, output logic [DW-1:0] q, output int lat);
    off_q.delete(); dat_q.delete(); lat_q.delete();
    rd_cycles = 0;
    cs = 1'b1; my_turn = 1'b1; data_in = din;
`ifdef CHORUS_MULTI_BYPASS_EN
    bypass = byp;
`endif
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        if (drop) begin my_turn = 1'b0; cs = 1'b0; end
        data_in = DW'($urandom);
`ifdef CHORUS_MULTI_BYPASS_EN
        bypass = 1'b0;
`endif
      end
    end while (!done && lat < 400);
    if (!done) check("done_timeout", int'(done), 1);
    q = data_out;
    if (!keep) begin my_turn = 1'b0; cs = 1'b0; end
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    samples++;
  endtask

  task automatic model_sample(input string nm, input logic [DW-1:0] din,
                              input bit drop, input bit keep, input bit byp);
    logic [DW-1:0] q;
    int lat, k, sum, exp_lat, exp_q;
    k = samples;
    run_sample(din, drop, keep, byp, q, lat);
    if (byp) begin
      check({nm, "_out"}, int'($signed(q)), int'($signed(din)));
      check({nm, "_lat"}, lat, 2);
      check({nm, "_rd"}, rd_cycles, 0);
    end else begin
      check({nm, "_reads"}, off_q.size(), V);
      sum = 0;
      exp_lat = 1 + (V - 1) + 2;
      for (int v = 0; v < V && v < off_q.size(); v++) begin
        check({nm, "_off"}, off_q[v], BASE + tri_wave(v * (1 << LW) / V + k / DIV));
        sum += dat_q[v];
        exp_lat += lat_q[v];
      end
      exp_q = floor_div(int'($signed(din)), 2) + floor_div(sum, 2 * V);
      check({nm, "_out"}, int'($signed(q)), exp_q);
      check({nm, "_lat"}, lat, exp_lat);
    end
  endtask

  typedef struct {
    logic [DW-1:0] din;
    int            lat;
    int            exp_out;
    int            off0;
    int            off1;
    int            exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q;
    int lat, n;

    vecs[0] = '{16'd4,      3, 290,    512, 640, 10};
    vecs[1] = '{16'd4,      3, 290,    513, 641, 10};
    vecs[2] = '{16'hFFFB,   1, 286,    514, 642, 6};
    vecs[3] = '{16'h7FFF,   2, 16672,  515, 643, 8};
    vecs[4] = '{16'h8000,   4, -16094, 516, 644, 12};

    rst = 1'b1; cs = 1'b0; my_turn = 1'b0; data_in = '0;
    cs4 = 1'b0; my_turn4 = 1'b0; data_in4 = '0;
    sram_read_finish = 1'b0; sram_data_in = '0; fin4 = 1'b0; d4 = '0;
`ifdef CHORUS_MULTI_BYPASS_EN
    bypass = 1'b0; bypass4 = 1'b0;
`endif
    cfg_lat = 3; cfg_rnd = 1'b0; cfg_spur = 1'b0; samples = 0;
    cnt = 0; cnt4 = 0; rd_cycles = 0;

    repeat (3) @(negedge clk);
    check("reset_done", int'(done), 0);
    check("reset_data_out", int'(data_out), 0);
    check("reset_sram_rd", int'(sram_rd), 0);
    check("reset_offset", int'(sram_offset), 0);
    check("reset_done4", int'(done4), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      cfg_lat = vecs[i].lat;
      run_sample(vecs[i].din, 1'b0, 1'b0, 1'b0, q, lat);
      check("vec_out", int'($signed(q)), vecs[i].exp_out);
      check("vec_lat", lat, vecs[i].exp_lat);
      check("vec_reads", off_q.size(), 2);
      if (off_q.size() == 2) begin
        check("vec_off0", off_q[0], vecs[i].off0);
        check("vec_off1", off_q[1], vecs[i].off1);
      end
    end

    // Reset asserted while a read is pending.
    cfg_lat = 3;
    cs = 1'b1; my_turn = 1'b1; data_in = 16'd4;
    n = 0;
    do begin @(negedge clk); n++; end while (!sram_rd && n < 50);
    check("rd_before_reset", int'(sram_rd), 1);
    rst = 1'b1;
    #1;
    check("midreset_sram_rd", int'(sram_rd), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_data_out", int'(data_out), 0);
    check("midreset_offset", int'(sram_offset), 0);
    cs = 1'b0; my_turn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    samples = 0;
    @(negedge clk);
    run_sample(16'd4, 1'b0, 1'b0, 1'b0, q, lat);
    check("post_reset_out", int'($signed(q)), 290);
    check("post_reset_reads", off_q.size(), 2);
    if (off_q.size() == 2) begin
      check("post_reset_off0", off_q[0], 512);
      check("post_reset_off1", off_q[1], 640);
    end

    // Random data, random latency, spurious finish pulses, random grant drops.
    cfg_lat = 0; cfg_rnd = 1'b1; cfg_spur = 1'b1;
    while (samples < 127)
      model_sample("rand", DW'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    model_sample("turn_top", DW'($urandom), 1'b0, 1'b0, 1'b0);
    if (off_q.size() == 2) begin
      check("turn_top_v1", off_q[1], 767);
      check("turn_top_v0", off_q[0], 639);
    end
    model_sample("turn_down", DW'($urandom), 1'b0, 1'b0, 1'b0);
    if (off_q.size() == 2) begin
      check("turn_down_v1", off_q[1], 766);
      check("turn_down_v0", off_q[0], 640);
    end

    // Grant held high: one IDLE cycle between consecutive done pulses.
    for (int i = 0; i < 3; i++)
      model_sample("b2b", DW'($urandom), 1'b0, (i < 2), 1'b0);

`ifdef CHORUS_MULTI_BYPASS_EN
    model_sample("bypass", 16'h1234, 1'b0, 1'b0, 1'b1);
    model_sample("after_bypass", DW'($urandom), 1'b0, 1'b0, 1'b0);
`endif

    // Four voices, LFO stepping every second sample, negative mix.
    for (int s = 0; s < 3; s++) begin
      off4_q.delete();
      cs4 = 1'b1; my_turn4 = 1'b1; data_in4 = 16'hFFFD;
      n = 1;
      do begin
        @(negedge clk);
        n++;
        if (n == 2) begin my_turn4 = 1'b0; cs4 = 1'b0; data_in4 = 16'h4000; end
      end while (!done4 && n < 400);
      check("v4_lat", n, 14);
      check("v4_out", int'($signed(data_out4)), -6);
      check("v4_reads", off4_q.size(), 4);
      for (int v = 0; v < 4 && v < off4_q.size(); v++)
        check("v4_off", off4_q[v], BASE + 64 * v + s / DIV4);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
